// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a programmable clock divider.
// It applies ratio changes and stop requests only at output-period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] div_active
);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
  logic clk_out_q, clk_out_d, tick_q, tick_d, err_q, err_d;
  logic accept, legal, last, take, run_d;
  assign cfg_ready  = state_q != PEND;
  assign accept     = cfg_valid && cfg_ready;
  assign legal      = cfg_div >= CNT_W'(2);
  assign take       = accept && legal;
  assign last       = cnt_q == div_q - 1'b1;
  assign cfg_err    = err_q;
  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign busy       = state_q != IDLE;
  assign div_active = div_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    err_d   = accept && !legal;
    if (state_q == IDLE) begin
      div_d   = take ? cfg_div : div_q;
      state_d = en ? RUN : IDLE;
      cnt_d   = '0;
    end else if (!last) begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == RUN && take) begin
        state_d = PEND;
        pend_d  = cfg_div;
      end
    end else begin
      // A ratio accepted on the boundary cycle waits one full old period,
      // unless the output is stopping, in which case it lands directly.
      cnt_d   = '0;
      state_d = !en ? IDLE : (state_q == RUN && take) ? PEND : RUN;
      if (state_q == PEND) div_d = pend_q;
      else if (take && !en) div_d = cfg_div;
      pend_d = (state_q == RUN && take && en) ? cfg_div : pend_q;
    end
    run_d     = state_d != IDLE;
    clk_out_d = run_d && (cnt_d < (div_d >> 1));
    tick_d    = run_d && (cnt_d == '0);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      pend_q    <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end
endmodule
